// File: rtl/watch_set_controller.sv
// Time-setting sequencer: walks RUN/SET_HR/SET_MIN/SET_SEC on MODE releases and issues edit strobes.
// Optional ADJ auto-repeat in SET_HR/SET_MIN is built when AUTOREPEAT_EN is defined.
//
// state   | meaning
// --------+------------------------------------------------------
// RUN     | normal timekeeping, run_en = 1, display steady
// SET_HR  | hour field blinking, ADJ gives inc_hr
// SET_MIN | minute field blinking, ADJ gives inc_min
// SET_SEC | seconds stopped (run_en = 0), ADJ gives clr_sec
module watch_set_controller #(
    parameter int TIMEOUT_S     = 30,
    parameter int REPEAT_DELAY  = 16384,
    parameter int REPEAT_PERIOD = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       mode_up,
    input  logic       adj_up,
    input  logic       adj_held,
    output logic [1:0] edit_state,
    output logic       inc_hr,
    output logic       inc_min,
    output logic       clr_sec,
    output logic       run_en,
    output logic       blink
);

    localparam logic [1:0] ST_RUN = 2'd0;
    localparam logic [1:0] ST_HR  = 2'd1;
    localparam logic [1:0] ST_MIN = 2'd2;
    localparam logic [1:0] ST_SEC = 2'd3;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT_S);

    logic [1:0] state_q, state_d;
    logic [7:0] idle_q, idle_d;
    logic       blink_q, blink_d;
    logic       run_en_q, run_en_d;
    logic       inc_hr_q, inc_hr_d;
    logic       inc_min_q, inc_min_d;
    logic       clr_sec_q, clr_sec_d;
    logic       rpt_fire;
    logic       in_set;
    logic       btn_clear;

`ifdef AUTOREPEAT_EN
    localparam logic [14:0] RPT_DELAY  = 15'(REPEAT_DELAY);
    localparam logic [14:0] RPT_RELOAD = 15'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [14:0] rpt_q, rpt_d, rpt_nxt;

    // mode_up always changes state, so it both blocks a repeat strobe and clears the counter.
    always_comb begin
        rpt_nxt  = 15'd0;
        rpt_fire = 1'b0;
        if ((state_q == ST_HR || state_q == ST_MIN) && adj_held && !mode_up) begin
            if (rpt_q + 15'd1 == RPT_DELAY) begin
                rpt_fire = 1'b1;
                rpt_nxt  = RPT_RELOAD;
            end else begin
                rpt_nxt = rpt_q + 15'd1;
            end
        end
    end

    always_comb begin
        rpt_d = rpt_nxt;
        if (state_d != state_q) begin
            rpt_d = 15'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rpt_q <= 15'd0;
        end else begin
            rpt_q <= rpt_d;
        end
    end
`else
    logic unused_adj_held;
    assign unused_adj_held = adj_held;
    assign rpt_fire        = 1'b0;
`endif

    assign in_set    = (state_q != ST_RUN);
    assign btn_clear = mode_up | adj_up | rpt_fire;

    always_comb begin
        state_d   = state_q;
        idle_d    = idle_q;
        inc_hr_d  = 1'b0;
        inc_min_d = 1'b0;
        clr_sec_d = 1'b0;

        if (mode_up) begin
            state_d = state_q + 2'd1;
        end

        // A button clear beats a same-cycle tick, so a timeout never coincides with a press.
        if (!in_set || btn_clear) begin
            idle_d = 8'd0;
        end else if (tick_1hz) begin
            if (idle_q + 8'd1 == TIMEOUT_CNT) begin
                idle_d  = 8'd0;
                state_d = ST_RUN;
            end else begin
                idle_d = idle_q + 8'd1;
            end
        end

        if ((adj_up && !mode_up) || rpt_fire) begin
            case (state_q)
                ST_HR:   inc_hr_d  = 1'b1;
                ST_MIN:  inc_min_d = 1'b1;
                ST_SEC:  clr_sec_d = adj_up;
                default: ;
            endcase
        end
    end

    always_comb begin
        blink_d = blink_q;
        if (state_d == ST_RUN || state_d != state_q || adj_up || rpt_fire) begin
            blink_d = 1'b1;
        end else if (tick_1hz) begin
            blink_d = ~blink_q;
        end
    end

    assign run_en_d = (state_d != ST_SEC);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            idle_q    <= 8'd0;
            blink_q   <= 1'b1;
            run_en_q  <= 1'b1;
            inc_hr_q  <= 1'b0;
            inc_min_q <= 1'b0;
            clr_sec_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idle_q    <= idle_d;
            blink_q   <= blink_d;
            run_en_q  <= run_en_d;
            inc_hr_q  <= inc_hr_d;
            inc_min_q <= inc_min_d;
            clr_sec_q <= clr_sec_d;
        end
    end

    assign edit_state = state_q;
    assign inc_hr     = inc_hr_q;
    assign inc_min    = inc_min_q;
    assign clr_sec    = clr_sec_q;
    assign run_en     = run_en_q;
    assign blink      = blink_q;

endmodule

// File: tb/tb_watch_set_controller.sv
// Bench for watch_set_controller: expected strobes go into a scoreboard queue, a monitor pops them.
module tb_watch_set_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_1hz;
    logic       mode_up;
    logic       adj_up;
    logic       adj_held;
    logic [1:0] edit_state;
    logic       inc_hr;
    logic       inc_min;
    logic       clr_sec;
    logic       run_en;
    logic       blink;

    typedef struct {
        logic [2:0] code;
        int         cyc;
    } exp_t;

    exp_t sb_q[$];
    int   cyc       = 0;
    int   chk_cnt   = 0;
    int   pass_cnt  = 0;
    logic [1:0] exp_state = 2'd0;

    localparam logic [2:0] S_HR  = 3'b100;
    localparam logic [2:0] S_MIN = 3'b010;
    localparam logic [2:0] S_SEC = 3'b001;

    watch_set_controller #(.TIMEOUT_S(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_1hz   (tick_1hz),
        .mode_up    (mode_up),
        .adj_up     (adj_up),
        .adj_held   (adj_held),
        .edit_state (edit_state),
        .inc_hr     (inc_hr),
        .inc_min    (inc_min),
        .clr_sec    (clr_sec),
        .run_en     (run_en),
        .blink      (blink)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Called at a negedge; applies one cycle of inputs and returns at the next negedge.
    task automatic drive(input logic m, input logic a, input logic t);
        mode_up  = m;
        adj_up   = a;
        tick_1hz = t;
        @(negedge clk);
        mode_up  = 1'b0;
        adj_up   = 1'b0;
        tick_1hz = 1'b0;
    endtask

    task automatic push(input logic [2:0] code);
        exp_t e;
        e.code = code;
        e.cyc  = cyc + 1;
        sb_q.push_back(e);
    endtask

    task automatic mode_step();
        drive(1'b1, 1'b0, 1'b0);
        exp_state = exp_state + 2'd1;
        repeat (2) @(negedge clk);
    endtask

    task automatic scoreboard_monitor();
        logic [2:0] got;
        exp_t e;
        forever begin
            @(negedge clk);
            got = {inc_hr, inc_min, clr_sec};
            if (|got === 1'b1) begin
                chk_cnt++;
                if (sb_q.size() == 0) begin
                    $display("FAIL strobe_unexpected: got %b at cycle %0d, want none", got, cyc);
                end else begin
                    e = sb_q.pop_front();
                    if (got !== e.code || cyc !== e.cyc)
                        $display("FAIL strobe_match: got %b at cycle %0d, want %b at cycle %0d",
                                 got, cyc, e.code, e.cyc);
                    else
                        pass_cnt++;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mode_up  = 1'($urandom_range(0, 1));
            adj_up   = 1'($urandom_range(0, 1));
            tick_1hz = 1'($urandom_range(0, 1));
            adj_held = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk_cnt++;
            if (edit_state !== 2'd0 || {inc_hr, inc_min, clr_sec} !== 3'b000)
                $display("FAIL reset_hold: got state %0d strobes %b, want 0 000",
                         edit_state, {inc_hr, inc_min, clr_sec});
            else
                pass_cnt++;
        end
        rst_n = 1'b1; mode_up = 1'b0; adj_up = 1'b0; tick_1hz = 1'b0; adj_held = 1'b0;
        @(negedge clk);
        exp_state = 2'd0;
        chk_cnt++;
        if (edit_state !== 2'd0 || run_en !== 1'b1 || blink !== 1'b1)
            $display("FAIL reset_values: got state %0d run_en %b blink %b, want 0 1 1",
                     edit_state, run_en, blink);
        else
            pass_cnt++;
    endtask

    task automatic test_fsm_walk();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            exp_state = exp_state + 2'd1;
            chk_cnt++;
            if (edit_state !== exp_state || run_en !== (exp_state != 2'd3))
                $display("FAIL fsm_walk: got state %0d run_en %b, want %0d %b",
                         edit_state, run_en, exp_state, exp_state != 2'd3);
            else
                pass_cnt++;
            repeat (9) @(negedge clk);
        end
    endtask

    task automatic test_edits();
        mode_step();
        for (int i = 0; i < 3; i++) begin
            push(S_HR);
            drive(1'b0, 1'b1, 1'b0);
            repeat (3) @(negedge clk);
        end
        mode_step();
        mode_step();
        chk_cnt++;
        if (edit_state !== 2'd3 || run_en !== 1'b0)
            $display("FAIL set_sec_entry: got state %0d run_en %b, want 3 0", edit_state, run_en);
        else
            pass_cnt++;
        push(S_SEC);
        drive(1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        mode_step();
        drive(1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        chk_cnt++;
        if (edit_state !== 2'd0 || run_en !== 1'b1)
            $display("FAIL run_adj_ignored: got state %0d run_en %b, want 0 1", edit_state, run_en);
        else
            pass_cnt++;
    endtask

    task automatic test_collision();
        mode_step();
        mode_step();
        drive(1'b1, 1'b1, 1'b0);
        exp_state = 2'd3;
        chk_cnt++;
        if (edit_state !== 2'd3 || inc_min !== 1'b0)
            $display("FAIL collision: got state %0d inc_min %b, want 3 0", edit_state, inc_min);
        else
            pass_cnt++;
        repeat (2) @(negedge clk);
        mode_step();
    endtask

    task automatic test_timeout();
        logic [1:0] want_st [3] = '{2'd1, 2'd1, 2'd0};
        logic       want_bl [3] = '{1'b0, 1'b1, 1'b1};
        mode_step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1);
            chk_cnt++;
            if (edit_state !== want_st[i] || blink !== want_bl[i])
                $display("FAIL timeout_tick%0d: got state %0d blink %b, want %0d %b",
                         i + 1, edit_state, blink, want_st[i], want_bl[i]);
            else
                pass_cnt++;
            repeat (2) @(negedge clk);
        end
        exp_state = 2'd0;
        mode_step();
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        push(S_HR);
        drive(1'b0, 1'b1, 1'b0);
        chk_cnt++;
        if (blink !== 1'b1)
            $display("FAIL adj_blink: got blink %b, want 1", blink);
        else
            pass_cnt++;
        drive(1'b0, 1'b0, 1'b1);
        chk_cnt++;
        if (edit_state !== 2'd1)
            $display("FAIL timeout_adj_reset: got state %0d, want 1", edit_state);
        else
            pass_cnt++;
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        exp_state = 2'd0;
        chk_cnt++;
        if (edit_state !== 2'd0 || blink !== 1'b1)
            $display("FAIL timeout_after_adj: got state %0d blink %b, want 0 1", edit_state, blink);
        else
            pass_cnt++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_midop();
        mode_step();
        mode_step();
        mode_step();
        rst_n = 1'b0;
        drive(1'b0, 1'b1, 1'b0);
        rst_n = 1'b1;
        exp_state = 2'd0;
        chk_cnt++;
        if (edit_state !== 2'd0 || run_en !== 1'b1 || clr_sec !== 1'b0)
            $display("FAIL reset_midop: got state %0d run_en %b clr_sec %b, want 0 1 0",
                     edit_state, run_en, clr_sec);
        else
            pass_cnt++;
        repeat (2) @(negedge clk);
    endtask

`ifdef AUTOREPEAT_EN
    task automatic test_autorepeat();
        exp_t e;
        mode_step();
        mode_step();
        for (int k = 0; k < 3; k++) begin
            e.code = S_MIN;
            e.cyc  = cyc + 16384 + k * 4096;
            sb_q.push_back(e);
        end
        adj_held = 1'b1;
        repeat (16384 + 2 * 4096) @(negedge clk);
        adj_held = 1'b0;
        repeat (4) @(negedge clk);
        chk_cnt++;
        if (edit_state !== 2'd2)
            $display("FAIL autorepeat_state: got %0d, want 2", edit_state);
        else
            pass_cnt++;
        mode_step();
        mode_step();
    endtask
`endif

    initial begin
        rst_n = 1'b0; mode_up = 1'b0; adj_up = 1'b0; tick_1hz = 1'b0; adj_held = 1'b0;
        fork
            scoreboard_monitor();
        join_none
        @(negedge clk);
        test_reset();
        test_fsm_walk();
        test_edits();
        test_collision();
        test_timeout();
        test_reset_midop();
`ifdef AUTOREPEAT_EN
        test_autorepeat();
`endif
        repeat (4) @(negedge clk);
        chk_cnt++;
        if (sb_q.size() != 0)
            $display("FAIL strobe_missing: got %0d pending expected strobes, want 0", sb_q.size());
        else
            pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
